// File: rtl/grid_sequencer.sv
// grid_sequencer: holds the Life grid, drives it to an external next-state evaluator and
// commits the evaluator output after a fixed settle delay; also loads seeds and serves reads.
module grid_sequencer #(
  parameter int ROWS    = 48,
  parameter int COLS    = 80,
  parameter int SETTLE  = 4,
  parameter int GEN_DIV = 25000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 step,
  input  logic                 load_start,
  input  logic                 load_valid,
  input  logic                 load_bit,
  output logic                 load_ready,
  output logic [ROWS*COLS-1:0] grid_out,
  input  logic [ROWS*COLS-1:0] next_in,
  output logic                 stateready,
  input  logic [5:0]           rd_row,
  input  logic [6:0]           rd_col,
  output logic                 rd_cell,
  output logic [15:0]          generation,
  output logic                 busy
);

  localparam int CELLS = ROWS * COLS;
  localparam int SW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int TW    = $clog2(GEN_DIV);

  localparam logic [11:0]   PTR_LAST  = 12'(CELLS - 1);
  localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(GEN_DIV - 1);
  localparam logic [6:0]    ROWS_L    = 7'(ROWS);
  localparam logic [7:0]    COLS_L    = 8'(COLS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_KICK,
    S_SETTLE,
    S_COMMIT
  } state_e;

  state_e             state_q, state_d;
  logic [CELLS-1:0]   grid_q, grid_d;
  logic               sr_q, sr_d;
  logic [15:0]        gen_q, gen_d;
  logic [11:0]        ptr_q, ptr_d;
  logic [SW-1:0]      settle_q, settle_d;
  logic [TW-1:0]      tick_q, tick_d;
  logic               pend_q, pend_d;
  logic               rd_cell_q, rd_cell_d;
  logic               kick_entry;
  logic               rd_hit;
  logic [11:0]        rd_idx;

  // NOTE: every _d signal takes its hold value before the case so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    grid_d     = grid_q;
    sr_d       = sr_q;
    gen_d      = gen_q;
    ptr_d      = ptr_q;
    settle_d   = settle_q;
    kick_entry = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // A seed load outranks both a manual step and a pending tick.
        if (load_start) begin
          state_d = S_LOAD;
          ptr_d   = '0;
        end else if (step || pend_q) begin
          state_d    = S_KICK;
          kick_entry = 1'b1;
        end
      end

      S_LOAD: begin
        if (load_start) begin
          ptr_d = '0;
        end else if (load_valid) begin
          grid_d[ptr_q] = load_bit;
          if (ptr_q == PTR_LAST) begin
            state_d = S_IDLE;
            ptr_d   = '0;
            gen_d   = '0;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end

      S_KICK: begin
        sr_d     = ~sr_q;
        settle_d = SETTLE_LD;
        state_d  = S_SETTLE;
      end

      S_SETTLE: begin
        if (settle_q == '0) begin
          state_d = S_COMMIT;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end

      S_COMMIT: begin
        grid_d  = next_in;
        gen_d   = gen_q + 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Generation timebase; the pending flag remembers at most one tick and dies with run.
  always_comb begin
    tick_d = '0;
    pend_d = 1'b0;
    if (run) begin
      tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
      pend_d = (tick_q == TICK_LAST) || (pend_q && !kick_entry);
    end
  end

  always_comb begin
    rd_hit    = ({1'b0, rd_row} < ROWS_L) && ({1'b0, rd_col} < COLS_L);
    rd_idx    = 12'(rd_row) * 12'(COLS) + 12'(rd_col);
    rd_cell_d = rd_hit ? grid_q[rd_idx] : 1'b0;
  end

  // NOTE: the grid sits on the async reset with the rest of the state so a reset mid-load
  // discards the partial pattern; state updates here use <= only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      grid_q    <= '0;
      sr_q      <= 1'b0;
      gen_q     <= '0;
      ptr_q     <= '0;
      settle_q  <= '0;
      tick_q    <= '0;
      pend_q    <= 1'b0;
      rd_cell_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grid_q    <= grid_d;
      sr_q      <= sr_d;
      gen_q     <= gen_d;
      ptr_q     <= ptr_d;
      settle_q  <= settle_d;
      tick_q    <= tick_d;
      pend_q    <= pend_d;
      rd_cell_q <= rd_cell_d;
    end
  end

  assign grid_out   = grid_q;
  assign stateready = sr_q;
  assign generation = gen_q;
  assign rd_cell    = rd_cell_q;
  assign load_ready = (state_q == S_LOAD);
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_grid_sequencer.sv
// tb_grid_sequencer: randomized seeds and steps against a plain Life model; a monitor pops
// expected grid/generation results whenever busy falls, and expected read data one cycle on.
module tb_grid_sequencer;

  localparam int ROWS    = 48;
  localparam int COLS    = 80;
  localparam int N       = ROWS * COLS;
  localparam int SETTLE  = 2;
  localparam int GEN_DIV = 10;

  logic          clk;
  logic          rst;
  logic          run;
  logic          step;
  logic          load_start;
  logic          load_valid;
  logic          load_bit;
  logic          load_ready;
  logic [N-1:0]  grid_out;
  logic [N-1:0]  next_in;
  logic          stateready;
  logic [5:0]    rd_row;
  logic [6:0]    rd_col;
  logic          rd_cell;
  logic [15:0]   generation;
  logic          busy;

  grid_sequencer #(
    .ROWS(ROWS), .COLS(COLS), .SETTLE(SETTLE), .GEN_DIV(GEN_DIV)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .step(step),
    .load_start(load_start), .load_valid(load_valid), .load_bit(load_bit),
    .load_ready(load_ready), .grid_out(grid_out), .next_in(next_in),
    .stateready(stateready), .rd_row(rd_row), .rd_col(rd_col), .rd_cell(rd_cell),
    .generation(generation), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int idx(input int r, input int c);
    return r * COLS + c;
  endfunction

  // Reference Life rule on a torus: count the eight neighbours with modular row/col.
  function automatic logic [N-1:0] life(input logic [N-1:0] g);
    logic [N-1:0] nx;
    int n;
    nx = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (dr != 0 || dc != 0)
              n += int'(g[idx((r + dr + ROWS) % ROWS, (c + dc + COLS) % COLS)]);
        nx[idx(r, c)] = (n == 3) || (n == 2 && g[idx(r, c)]);
      end
    end
    return nx;
  endfunction

  // Combinational evaluator seen by the DUT.
  assign next_in = life(grid_out);

  typedef struct {
    logic [N-1:0] grid;
    logic [15:0]  gen;
    logic         sr;
    int           cyc;
  } done_exp_t;

  typedef struct {
    logic val;
    int   cyc;
  } rd_exp_t;

  done_exp_t    exp_q[$];
  rd_exp_t      rdq[$];
  logic [N-1:0] m_grid;
  int           m_gen;
  logic         m_sr;
  logic         auto_mode;
  int           n_checks = 0;
  int           n_pass   = 0;

  task automatic check(input string name, input logic ok, input longint act, input longint want);
    n_checks++;
    if (ok === 1'b1) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
  endtask

  // Monitor: read data one cycle after each request; a completion record on every busy fall.
  initial begin : monitor
    logic      busy_prev;
    logic      have;
    done_exp_t e;
    rd_exp_t   r;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rdq.size() > 0 && rdq[0].cyc == cyc) begin
        r = rdq.pop_front();
        check("rd_cell", rd_cell === r.val, rd_cell, r.val);
      end
      if (busy_prev === 1'b1 && busy === 1'b0) begin
        have = 1'b1;
        check("expected_done_queued", auto_mode || exp_q.size() > 0, exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
        end else if (auto_mode) begin
          m_grid = life(m_grid);
          m_gen++;
          m_sr   = ~m_sr;
          e.grid = m_grid;
          e.gen  = 16'(m_gen);
          e.sr   = m_sr;
          e.cyc  = -1;
        end else begin
          have = 1'b0;
        end
        if (have) begin
          check("done_grid_diff_cells", grid_out === e.grid, $countones(grid_out ^ e.grid), 0);
          check("done_generation", generation === e.gen, generation, e.gen);
          check("done_stateready", stateready === e.sr, stateready, e.sr);
          if (e.cyc >= 0) check("done_cycle", cyc == e.cyc, cyc, e.cyc);
        end
      end
      busy_prev = busy;
    end
  end

  task automatic push_done(input int due);
    done_exp_t e;
    e.grid = m_grid;
    e.gen  = 16'(m_gen);
    e.sr   = m_sr;
    e.cyc  = due;
    exp_q.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || rdq.size() > 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", exp_q.size() == 0 && rdq.size() == 0, exp_q.size() + rdq.size(), 0);
    exp_q.delete();
    rdq.delete();
  endtask

  task automatic rd_req(input int r, input int c);
    rd_exp_t x;
    rd_row = 6'(r);
    rd_col = 7'(c);
    x.val  = (r < ROWS && c < COLS) ? m_grid[idx(r, c)] : 1'b0;
    x.cyc  = cyc + 1;
    rdq.push_back(x);
    @(negedge clk);
  endtask

  task automatic random_reads(input int k);
    for (int i = 0; i < k; i++) rd_req(int'($urandom_range(63)), int'($urandom_range(127)));
    drain(10);
  endtask

  // Serial seed with random gaps. restart_at: pulse load_start after that many bits, then
  // reload from bit 0. reset_at: assert rst after that many bits and abandon the load.
  task automatic load_grid(input logic [N-1:0] pat, input int restart_at, input int reset_at);
    int   i;
    logic restarted;
    logic aborted;
    i = 0; restarted = 1'b0; aborted = 1'b0;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    check("load_ready_high", load_ready === 1'b1, load_ready, 1);
    while (i < N && !aborted) begin
      if (i == restart_at && !restarted) begin
        load_valid = 1'b0;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        restarted  = 1'b1;
        i = 0;
      end else if (i == reset_at) begin
        load_valid = 1'b0;
        m_grid = '0; m_gen = 0; m_sr = 1'b0;
        push_done(-1);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_mid_load_ready", load_ready === 1'b0, load_ready, 0);
        check("rst_mid_load_grid", grid_out === '0, $countones(grid_out), 0);
        check("rst_mid_load_busy", busy === 1'b0, busy, 0);
        rst = 1'b0;
        aborted = 1'b1;
      end else begin
        if ($urandom_range(7) == 0) begin
          load_valid = 1'b0;
          load_bit   = 1'($urandom);
        end else begin
          load_valid = 1'b1;
          load_bit   = pat[i];
          if (i == N - 1) begin
            m_grid = pat; m_gen = 0;
            push_done(cyc + 1);
          end
          i++;
        end
        @(negedge clk);
      end
    end
    load_valid = 1'b0;
  endtask

  task automatic single_step(input logic poke_in_settle);
    step = 1'b1;
    m_grid = life(m_grid); m_gen++; m_sr = ~m_sr;
    push_done(cyc + 1 + SETTLE + 2);
    @(negedge clk);
    step = 1'b0;
    check("stateready_not_yet", stateready === ~m_sr, stateready, ~m_sr);
    @(negedge clk);
    check("stateready_toggled", stateready === m_sr, stateready, m_sr);
    if (poke_in_settle) begin
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
    end
  endtask

  task automatic step_burst(input int k);
    int t0;
    step = 1'b1;
    t0 = cyc + 1;
    for (int j = 0; j < k; j++) begin
      m_grid = life(m_grid); m_gen++; m_sr = ~m_sr;
      push_done(t0 + SETTLE + 2 + j * (SETTLE + 3));
    end
    repeat ((k - 1) * (SETTLE + 3) + 1) @(negedge clk);
    step = 1'b0;
  endtask

  function automatic logic [N-1:0] rand_grid();
    logic [N-1:0] g;
    for (int i = 0; i < N / 32; i++) g[i*32 +: 32] = $urandom;
    return g;
  endfunction

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin : driver
    logic [N-1:0] pat;
    logic [N-1:0] shifted;
    int           g0;
    int           gr [5];
    int           gc [5];
    gr = '{0, 1, 2, 2, 2};
    gc = '{1, 2, 0, 1, 2};

    rst = 1'b1; run = 1'b0; step = 1'b0; load_start = 1'b0; load_valid = 1'b0;
    load_bit = 1'b0; rd_row = '0; rd_col = '0; auto_mode = 1'b0;
    m_grid = '0; m_gen = 0; m_sr = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_grid", grid_out === '0, $countones(grid_out), 0);
    check("reset_stateready", stateready === 1'b0, stateready, 0);
    check("reset_generation", generation === 16'd0, generation, 0);
    check("reset_rd_cell", rd_cell === 1'b0, rd_cell, 0);
    check("reset_load_ready", load_ready === 1'b0, load_ready, 0);
    check("reset_busy", busy === 1'b0, busy, 0);
    rst = 1'b0;
    @(negedge clk);
    rd_req(47, 79); rd_req(50, 10); rd_req(0, 0); rd_req(20, 100); rd_req(63, 127);
    drain(10);

    // Horizontal blinker becomes vertical after one generation.
    pat = '0;
    pat[idx(10, 20)] = 1'b1; pat[idx(10, 21)] = 1'b1; pat[idx(10, 22)] = 1'b1;
    load_grid(pat, -1, -1);
    drain(10);
    single_step(1'b0);
    drain(20);
    check("blinker_vertical", grid_out[idx(9, 21)] & grid_out[idx(10, 21)] & grid_out[idx(11, 21)],
          $countones(grid_out), 3);
    check("blinker_ends_off", !grid_out[idx(10, 20)] && !grid_out[idx(10, 22)],
          {grid_out[idx(10, 20)], grid_out[idx(10, 22)]}, 0);
    check("blinker_gen", generation === 16'd1, generation, 1);
    for (int r = 8; r <= 12; r++) for (int c = 19; c <= 23; c += 2) rd_req(r, c);
    rd_req(9, 21); rd_req(11, 21);
    drain(10);

    // Glider straddling both wrap seams; four generations move it by (+1,+1).
    pat = '0; shifted = '0;
    for (int k = 0; k < 5; k++) begin
      pat[idx((46 + gr[k]) % ROWS, (78 + gc[k]) % COLS)]     = 1'b1;
      shifted[idx((47 + gr[k]) % ROWS, (79 + gc[k]) % COLS)] = 1'b1;
    end
    load_grid(pat, -1, -1);
    drain(10);
    repeat (4) begin
      single_step(1'b0);
      drain(20);
    end
    check("glider_shift_diff_cells", grid_out === shifted, $countones(grid_out ^ shifted), 0);
    check("glider_gen", generation === 16'd4, generation, 4);
    rd_req(47, 0); rd_req(0, 0); rd_req(1, 79); rd_req(1, 0); rd_req(1, 1);
    drain(10);

    // Random soup: back-to-back steps, then a step poked during SETTLE that must be dropped.
    load_grid(rand_grid(), -1, -1);
    drain(10);
    step_burst(3);
    drain(40);
    single_step(1'b1);
    repeat (12) @(negedge clk);
    drain(20);
    random_reads(30);

    // Free-running generations from the tick divider.
    auto_mode = 1'b1;
    g0 = m_gen;
    run = 1'b1;
    repeat (100) @(negedge clk);
    run = 1'b0;
    repeat (15) @(negedge clk);
    auto_mode = 1'b0;
    check("run_generations", (m_gen - g0) >= 9 && (m_gen - g0) <= 11, m_gen - g0, 10);
    check("run_gen_output", generation === 16'(m_gen), generation, m_gen);
    repeat (30) @(negedge clk);
    drain(5);
    random_reads(20);

    // Reset after 1000 seed bits, then a clean full load.
    load_grid(rand_grid(), -1, 1000);
    @(negedge clk);
    drain(10);
    rd_req(47, 79); rd_req(0, 0);
    random_reads(10);
    load_grid(rand_grid(), -1, -1);
    drain(10);
    random_reads(20);

    // load_start at bit 500 restarts; completion cycle is checked by the monitor.
    load_grid(rand_grid(), 500, -1);
    drain(10);
    random_reads(20);
    check("restart_gen_zero", generation === 16'd0, generation, 0);

    // Reset during SETTLE: nothing commits, everything returns to zero.
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    m_grid = '0; m_gen = 0; m_sr = 1'b0;
    push_done(-1);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_settle_grid", grid_out === '0, $countones(grid_out), 0);
    check("rst_settle_gen", generation === 16'd0, generation, 0);
    check("rst_settle_stateready", stateready === 1'b0, stateready, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    drain(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
